rename_alloc_seq: RTL and testbench

RENAME_ALLOC_SEQ -- requirements
Module: rename_alloc_seq

---
 rtl/rename_alloc_seq.sv | 137 +++++++++++++
 tb/tb_rename_alloc_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_alloc_seq.sv
// Two-requester rename allocator with a FIFO of in-flight names that is retired by COMMIT.
// Optional saturating stall counter: define RENAME_ALLOC_SEQ_STALL_CNT_EN.
module rename_alloc_seq #(
  parameter int unsigned addr_width = 1,
  parameter int unsigned name_width = 1,
  parameter int unsigned depth      = 4,
  parameter int unsigned cnt_width  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_0,
  input  logic                  REQ_1,
  input  logic [addr_width-1:0] ADDR_0,
  input  logic [addr_width-1:0] ADDR_1,
  output logic                  GNT_0,
  output logic                  GNT_1,
  output logic [name_width-1:0] NAME_GNT,
  output logic [addr_width-1:0] RF_ADDR_IN,
  output logic                  RF_ALLOC_E,
  input  logic                  RF_ALLOC_READY,
  input  logic [name_width-1:0] RF_NAME_OUT,
  input  logic                  COMMIT,
  output logic [name_width-1:0] RF_NAME_F,
  output logic                  RF_FE,
  output logic [cnt_width-1:0]  COUNT,
  output logic                  FULL,
  output logic                  EMPTY
`ifdef RENAME_ALLOC_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]           STALL_CNT
`endif
);

  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [cnt_width-1:0]  count_q, count_d;
  logic                  prio_q, prio_d;
  logic                  fe_q, fe_d;
  logic [name_width-1:0] name_f_q, name_f_d;
  logic [name_width-1:0] mem_q [depth];

  logic eligible;
  logic gnt0, gnt1;
  logic alloc;
  logic pop;

  assign FULL  = (count_q == cnt_width'(depth));
  assign EMPTY = (count_q == '0);
  assign COUNT = count_q;

  // RST gates the grants so they drop the moment reset asserts, independent of REQ.
  assign eligible = RST & RF_ALLOC_READY & ~FULL;
  assign gnt0     = eligible & REQ_0 & (~REQ_1 | ~prio_q);
  assign gnt1     = eligible & REQ_1 & (~REQ_0 |  prio_q);
  assign alloc    = gnt0 | gnt1;
  // An empty queue never pops, so a same-cycle write cannot be retired early.
  assign pop      = COMMIT & ~EMPTY;

  assign GNT_0      = gnt0;
  assign GNT_1      = gnt1;
  assign RF_ALLOC_E = alloc;
  assign RF_ADDR_IN = gnt1 ? ADDR_1 : ADDR_0;
  assign NAME_GNT   = RF_NAME_OUT;
  assign RF_FE      = fe_q;
  assign RF_NAME_F  = name_f_q;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    prio_d   = prio_q;
    fe_d     = pop;
    name_f_d = name_f_q;

    if (alloc) begin
      tail_d = tail_q + PW'(1);
      prio_d = gnt0;
    end
    if (pop) begin
      head_d   = head_q + PW'(1);
      name_f_d = mem_q[head_q];
    end
    unique case ({alloc, pop})
      2'b10:   count_d = count_q + cnt_width'(1);
      2'b01:   count_d = count_q - cnt_width'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      prio_q   <= 1'b0;
      fe_q     <= 1'b0;
      name_f_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      prio_q   <= prio_d;
      fe_q     <= fe_d;
      name_f_q <= name_f_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (alloc) begin
      mem_q[tail_q] <= RF_NAME_OUT;
    end
  end

`ifdef RENAME_ALLOC_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((REQ_0 | REQ_1) && !alloc && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_rename_alloc_seq.sv
// Bench for rename_alloc_seq: directed vector table, reset-mid-operation sequence,
// and random traffic checked against a queue-based reference model.
module tb_rename_alloc_seq;

  localparam int AW = 3;
  localparam int NW = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          REQ_0 = 1'b0, REQ_1 = 1'b0;
  logic [AW-1:0] ADDR_0 = '0, ADDR_1 = '0;
  logic          GNT_0, GNT_1;
  logic [NW-1:0] NAME_GNT;
  logic [AW-1:0] RF_ADDR_IN;
  logic          RF_ALLOC_E;
  logic          RF_ALLOC_READY = 1'b0;
  logic [NW-1:0] RF_NAME_OUT = '0;
  logic          COMMIT = 1'b0;
  logic [NW-1:0] RF_NAME_F;
  logic          RF_FE;
  logic [CW-1:0] COUNT;
  logic          FULL, EMPTY;
`ifdef RENAME_ALLOC_SEQ_STALL_CNT_EN
  logic [15:0]   STALL_CNT;
`endif

  rename_alloc_seq #(
    .addr_width(AW),
    .name_width(NW),
    .depth(D),
    .cnt_width(CW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ_0(REQ_0), .REQ_1(REQ_1), .ADDR_0(ADDR_0), .ADDR_1(ADDR_1),
    .GNT_0(GNT_0), .GNT_1(GNT_1), .NAME_GNT(NAME_GNT),
    .RF_ADDR_IN(RF_ADDR_IN), .RF_ALLOC_E(RF_ALLOC_E),
    .RF_ALLOC_READY(RF_ALLOC_READY), .RF_NAME_OUT(RF_NAME_OUT),
    .COMMIT(COMMIT), .RF_NAME_F(RF_NAME_F), .RF_FE(RF_FE),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
`ifdef RENAME_ALLOC_SEQ_STALL_CNT_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int q[$];
  bit prio_m;
  bit fe_m;
  int nf_m;
  int stall_m;

  typedef struct {
    int r0, r1, rdy, cm, nm;
    int eg0, eg1, ecnt, efe, enf;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input int r0, r1, rdy, cm, nm, eg0, eg1, ecnt, efe, enf);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.rdy = rdy; v.cm = cm; v.nm = nm;
    v.eg0 = eg0; v.eg1 = eg1; v.ecnt = ecnt; v.efe = efe; v.enf = enf;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit r0, r1, input int a0, a1, input bit rdy, input int nm, input bit cm);
    REQ_0 = r0; REQ_1 = r1;
    ADDR_0 = AW'(a0); ADDR_1 = AW'(a1);
    RF_ALLOC_READY = rdy;
    RF_NAME_OUT = NW'(nm);
    COMMIT = cm;
  endtask

  task automatic model_clear();
    q.delete();
    prio_m = 1'b0; fe_m = 1'b0; nf_m = 0; stall_m = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic mcycle(input bit r0, r1, input int a0, a1, input bit rdy, input int nm, input bit cm);
    bit elig, g0, g1, popping;
    drive(r0, r1, a0, a1, rdy, nm, cm);
    #4;
    elig = rdy && (q.size() < D);
    g0 = elig && r0 && (!r1 || !prio_m);
    g1 = elig && r1 && (!r0 || prio_m);
    chk("gnt0", GNT_0, g0);
    chk("gnt1", GNT_1, g1);
    chk("alloc_e", RF_ALLOC_E, g0 | g1);
    chk("rf_addr", RF_ADDR_IN, g1 ? a1 : a0);
    chk("name_gnt", NAME_GNT, nm);
    chk("count", COUNT, q.size());
    chk("full", FULL, q.size() == D);
    chk("empty", EMPTY, q.size() == 0);
`ifdef RENAME_ALLOC_SEQ_STALL_CNT_EN
    chk("stall_cnt", STALL_CNT, stall_m);
`endif
    @(posedge CLK); #1;
    popping = cm && (q.size() != 0);
    if (popping) nf_m = q.pop_front();
    fe_m = popping;
    if (g0 || g1) begin
      q.push_back(nm);
      prio_m = g0;
    end
    if ((r0 || r1) && !(g0 || g1) && stall_m < 65535) stall_m++;
    chk("rf_fe", RF_FE, fe_m);
    chk("rf_name_f", RF_NAME_F, nf_m);
  endtask

  task automatic do_reset();
    drive(1, 1, 2, 6, 1, 5, 1);
    RST = 1'b0;
    #2;
    chk("rst_gnt0", GNT_0, 0);
    chk("rst_gnt1", GNT_1, 0);
    chk("rst_alloc_e", RF_ALLOC_E, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_fe", RF_FE, 0);
    chk("rst_name_f", RF_NAME_F, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    model_clear();
  endtask

  initial begin
    // Directed table: r0 r1 rdy cm nm | eg0 eg1 count(pre-edge) fe nf(post-edge)
    add(1,1,1,0,2, 1,0,0,0,0);
    add(1,1,1,0,3, 0,1,1,0,0);
    add(1,1,1,0,4, 1,0,2,0,0);
    add(1,1,1,0,5, 0,1,3,0,0);
    add(1,0,1,0,6, 0,0,4,0,0);
    add(1,0,1,1,6, 0,0,4,1,2);
    add(1,0,1,0,6, 1,0,3,0,2);
    add(0,0,1,1,0, 0,0,4,1,3);
    add(0,0,1,1,0, 0,0,3,1,4);
    add(0,0,1,1,0, 0,0,2,1,5);
    add(0,0,1,1,0, 0,0,1,1,6);
    add(0,0,1,1,0, 0,0,0,0,6);
    add(1,0,1,0,6, 1,0,0,0,6);
    add(1,0,1,0,7, 1,0,1,0,6);
    add(0,0,1,1,0, 0,0,2,1,6);
    add(0,0,1,1,0, 0,0,1,1,7);
    add(0,0,1,1,0, 0,0,0,0,7);
    add(0,1,1,0,8, 0,1,0,0,7);
    add(0,1,1,0,1, 0,1,1,0,7);
    add(1,0,1,1,9, 1,0,2,1,8);
    add(0,0,1,1,0, 0,0,2,1,1);
    add(0,0,1,1,0, 0,0,1,1,9);
    add(0,0,1,0,0, 0,0,0,0,9);
    add(1,0,1,1,3, 1,0,0,0,9);
    add(0,0,1,1,0, 0,0,1,1,3);
    add(0,0,1,0,0, 0,0,0,0,3);
    add(0,1,0,0,4, 0,0,0,0,3);

    #3;
    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].r0[0], tbl[i].r1[0], 1, 5, tbl[i].rdy[0], tbl[i].nm, tbl[i].cm[0]);
      #4;
      chk($sformatf("tbl%0d_gnt0", i), GNT_0, tbl[i].eg0);
      chk($sformatf("tbl%0d_gnt1", i), GNT_1, tbl[i].eg1);
      chk($sformatf("tbl%0d_alloc_e", i), RF_ALLOC_E, tbl[i].eg0 | tbl[i].eg1);
      chk($sformatf("tbl%0d_addr", i), RF_ADDR_IN, (tbl[i].eg1 != 0) ? 5 : 1);
      chk($sformatf("tbl%0d_name_gnt", i), NAME_GNT, tbl[i].nm);
      chk($sformatf("tbl%0d_count", i), COUNT, tbl[i].ecnt);
      chk($sformatf("tbl%0d_full", i), FULL, tbl[i].ecnt == D);
      chk($sformatf("tbl%0d_empty", i), EMPTY, tbl[i].ecnt == 0);
      @(posedge CLK); #1;
      chk($sformatf("tbl%0d_fe", i), RF_FE, tbl[i].efe);
      chk($sformatf("tbl%0d_name_f", i), RF_NAME_F, tbl[i].enf);
    end

    // Reset in the middle of a cycle with three entries queued and a free pulse in flight.
    do_reset();
    mcycle(1, 0, 2, 0, 1, 1, 0);
    mcycle(0, 1, 2, 6, 1, 2, 0);
    mcycle(1, 0, 3, 6, 1, 3, 0);
    mcycle(1, 0, 4, 6, 1, 4, 1);
    chk("pre_rst_count", COUNT, 3);
    drive(1, 1, 1, 7, 1, 5, 0);
    #2;
    RST = 1'b0;
    #1;
    chk("async_count", COUNT, 0);
    chk("async_empty", EMPTY, 1);
    chk("async_fe", RF_FE, 0);
    chk("async_name_f", RF_NAME_F, 0);
    chk("async_gnt0", GNT_0, 0);
    chk("async_gnt1", GNT_1, 0);
    chk("async_alloc_e", RF_ALLOC_E, 0);
    #3;
    RST = 1'b1;
    model_clear();
    #1;
    chk("post_rst_gnt0", GNT_0, 1);
    chk("post_rst_gnt1", GNT_1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    mcycle(1, 1, 1, 7, 1, 5, 0);

    // Random traffic against the queue model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      mcycle($urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 15),
             $urandom_range(0, 2) == 0);
    end

    // Resource wait: requester 1 stalls while the rename file has nothing free
    for (int n = 0; n < 6; n++) begin
      mcycle(0, 1, 0, 3, 0, 2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
